// File: rtl/gray_ptr_rx_pkg.sv
// Gray-code helpers shared by the pointer receiver, the matching encoder and
// the async FIFO. Functions work on a fixed 32-bit word; callers zero-extend
// narrower pointers, which leaves both conversions correct for any W <= 32.
package gray_ptr_rx_pkg;

  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] word_t;

  // Binary to reflected gray: neighbouring values differ in exactly one bit.
  function automatic word_t bin_to_gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic word_t gray_to_bin(input word_t g);
    word_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Number of set bits. Used to detect multi-bit gray transitions.
  function automatic int unsigned popcount(input word_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_ptr_rx_if.sv
// Bus between the foreign-domain pointer source and the gray receiver.
// master: side that supplies the gray pointer and clears errors.
// slave : the receiver itself.
interface gray_ptr_rx_if #(
  parameter int W = 8
);
  logic [W-1:0] gray_in;
  logic         err_clr;
  logic [W-1:0] bin_out;
  logic         changed;
  logic [W-1:0] delta;
  logic         err;

  modport master (
    output gray_in, err_clr,
    input  bin_out, changed, delta, err
  );

  modport slave (
    input  gray_in, err_clr,
    output bin_out, changed, delta, err
  );
endinterface

// File: rtl/gray_ptr_rx_sync_ff.sv
// Multi-flop synchroniser for a gray word arriving from another clock domain.
// Because the source only ever changes one bit per step, per-bit
// synchronisation yields either the old or the new word, never a blend.
module sync_ff #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [STAGES];
  logic [W-1:0] stage_d [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_d[gi] = d;
      end else begin : g_rest
        assign stage_d[gi] = stage_q[gi-1];
      end

      // One synchroniser stage, cleared to zero on reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q[gi] <= '0;
        else     stage_q[gi] <= stage_d[gi];
      end
    end
  endgenerate

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_rx.sv
// Consumer side of a gray-coded pointer crossing: synchronise, detect updates,
// decode to binary, report step size and flag multi-bit (illegal) transitions.
module gray_ptr_rx
  import gray_ptr_rx_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  gray_ptr_rx_if.slave bus
);

  logic [W-1:0] g_s;
  logic [W-1:0] dec;
  logic         update;
  logic         multi_bit;

  logic [W-1:0] g_p_q,     g_p_d;
  logic [W-1:0] bin_q,     bin_d;
  logic [W-1:0] delta_q,   delta_d;
  logic         changed_q, changed_d;
  logic         err_q,     err_d;

  sync_ff #(
    .W      (W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.gray_in),
    .q   (g_s)
  );

  // Update detection, decode and error/step computation for the next cycle.
  always_comb begin
    update    = (g_s != g_p_q);
    dec       = W'(gray_to_bin(word_t'(g_s)));
    multi_bit = (popcount(word_t'(g_s ^ g_p_q)) > 1);

    g_p_d     = g_p_q;
    bin_d     = bin_q;
    delta_d   = delta_q;
    changed_d = 1'b0;
    err_d     = err_q;

    if (update) begin
      g_p_d     = g_s;
      bin_d     = dec;
      delta_d   = dec - bin_q;
      changed_d = 1'b1;
    end

    // A fresh error outranks a clear arriving in the same cycle.
    if (update && multi_bit) err_d = 1'b1;
    else if (bus.err_clr)    err_d = 1'b0;
  end

  // Receiver state; zero reset makes gray 0 the initial reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_p_q     <= '0;
      bin_q     <= '0;
      delta_q   <= '0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      g_p_q     <= g_p_d;
      bin_q     <= bin_d;
      delta_q   <= delta_d;
      changed_q <= changed_d;
      err_q     <= err_d;
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.delta   = delta_q;
  assign bus.changed = changed_q;
  assign bus.err     = err_q;

endmodule
